// File: rtl/u8_rst_pkg.sv
// ============================================================================
// Module      : u8_rst_pkg
// Description : Shared types, defaults and width helper for the u8 lock-
//               qualified reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package u8_rst_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam int c_DEF_SYNC_STAGES        = 2;
    localparam int c_DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int c_DEF_RST_HOLD_CYCLES    = 16;
    localparam int c_DEF_LOSS_CNT_W         = 8;
    localparam int c_DEF_TIMEOUT_CYCLES     = 65536;

    // Bits needed to hold values 0..max_val inclusive, never less than one.
    function automatic int cnt_w(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/u8_sync_ff.sv
// ============================================================================
// Module      : u8_sync_ff
// Description : STAGES-deep single-bit synchroniser with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module u8_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/u8_lock_rst_seq.sv
// ============================================================================
// Module      : u8_lock_rst_seq
// Description : Qualifies the FCCC LOCK flag and sequences SYS_RST for the
//               fabric on CLK0; counts lock losses seen in RUN.
//               Optional lock watchdog enabled by macro U8_LOCK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module u8_lock_rst_seq
    import u8_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = c_DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = c_DEF_LOCK_STABLE_CYCLES,
    parameter int RST_HOLD_CYCLES    = c_DEF_RST_HOLD_CYCLES,
`ifdef U8_LOCK_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES     = c_DEF_TIMEOUT_CYCLES,
`endif
    parameter int LOSS_CNT_W         = c_DEF_LOSS_CNT_W
) (
    input  logic                  CLK0,
    input  logic                  RESET,
    input  logic                  LOCK,
    output logic                  SYS_RST,
    output logic                  READY,
    output logic [LOSS_CNT_W-1:0] LOSS_CNT
`ifdef U8_LOCK_TIMEOUT_EN
    ,
    output logic                  LOCK_TIMEOUT
`endif
);

    localparam logic [1:0] c_WAIT_LOCK = ST_WAIT_LOCK;
    localparam logic [1:0] c_STABLE    = ST_STABLE;
    localparam logic [1:0] c_HOLD      = ST_HOLD;
    localparam logic [1:0] c_RUN       = ST_RUN;

    localparam int c_STAB_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int c_HOLD_W = cnt_w(RST_HOLD_CYCLES);

    localparam logic [c_STAB_W-1:0]   c_STAB_MAX = c_STAB_W'(LOCK_STABLE_CYCLES);
    localparam logic [c_STAB_W-1:0]   c_STAB_ONE = c_STAB_W'(1);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_MAX = c_HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [c_HOLD_W-1:0]   c_HOLD_ONE = c_HOLD_W'(1);
    localparam logic [LOSS_CNT_W-1:0] c_LOSS_ONE = LOSS_CNT_W'(1);

    logic                  w_lock_s;
    logic [1:0]            r_state;
    logic [1:0]            w_state_nx;
    logic [c_STAB_W-1:0]   r_stab_cnt;
    logic [c_STAB_W-1:0]   w_stab_nx;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_HOLD_W-1:0]   w_hold_nx;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic [LOSS_CNT_W-1:0] w_loss_nx;
    logic                  r_sys_rst;
    logic                  r_ready;

    u8_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (CLK0),
        .rst (RESET),
        .d   (LOCK),
        .q   (w_lock_s)
    );

    always_comb begin
        w_state_nx = r_state;
        w_stab_nx  = r_stab_cnt;
        w_hold_nx  = r_hold_cnt;
        w_loss_nx  = r_loss_cnt;
        case (r_state)
            c_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nx = c_STABLE;
                    w_stab_nx  = c_STAB_ONE;
                end
            end
            c_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nx = c_WAIT_LOCK;
                    w_stab_nx  = '0;
                end else if (r_stab_cnt == c_STAB_MAX) begin
                    w_state_nx = c_HOLD;
                    w_stab_nx  = '0;
                    w_hold_nx  = c_HOLD_ONE;
                end else begin
                    w_stab_nx  = r_stab_cnt + c_STAB_ONE;
                end
            end
            c_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nx = c_WAIT_LOCK;
                    w_hold_nx  = '0;
                end else if (r_hold_cnt == c_HOLD_MAX) begin
                    w_state_nx = c_RUN;
                    w_hold_nx  = '0;
                end else begin
                    w_hold_nx  = r_hold_cnt + c_HOLD_ONE;
                end
            end
            c_RUN: begin
                if (!w_lock_s) begin
                    w_state_nx = c_WAIT_LOCK;
                    if (r_loss_cnt != '1) begin
                        w_loss_nx = r_loss_cnt + c_LOSS_ONE;
                    end
                end
            end
            default: begin
                w_state_nx = c_WAIT_LOCK;
                w_stab_nx  = '0;
                w_hold_nx  = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the FSM.
    always_ff @(posedge CLK0) begin
        if (RESET) begin
            r_state    <= c_WAIT_LOCK;
            r_stab_cnt <= '0;
            r_hold_cnt <= '0;
            r_loss_cnt <= '0;
            r_sys_rst  <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_stab_cnt <= w_stab_nx;
            r_hold_cnt <= w_hold_nx;
            r_loss_cnt <= w_loss_nx;
            r_sys_rst  <= (w_state_nx != c_RUN);
            r_ready    <= (w_state_nx == c_RUN);
        end
    end

    assign SYS_RST  = r_sys_rst;
    assign READY    = r_ready;
    assign LOSS_CNT = r_loss_cnt;

`ifdef U8_LOCK_TIMEOUT_EN
    localparam int c_WD_W = cnt_w(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_MAX  = c_WD_W'(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_lock_timeout;

    // Watchdog saturates at the limit; the flag stays set until RESET.
    always_ff @(posedge CLK0) begin
        if (RESET) begin
            r_wd_cnt       <= '0;
            r_lock_timeout <= 1'b0;
        end else if (r_state == c_RUN) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != c_WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + c_WD_ONE;
            if (r_wd_cnt == c_WD_LAST) begin
                r_lock_timeout <= 1'b1;
            end
        end
    end

    assign LOCK_TIMEOUT = r_lock_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_u8_lock_rst_seq.sv
// ============================================================================
// Module      : tb_u8_lock_rst_seq
// Description : Directed scoreboard bench for u8_lock_rst_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_u8_lock_rst_seq;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       sys_rst;
    logic       ready;
    logic [1:0] loss_cnt;
`ifdef U8_LOCK_TIMEOUT_EN
    logic       lock_timeout;
`endif

    typedef struct {
        int         cyc;
        logic       rst;
        logic       rdy;
        logic [1:0] loss;
        logic       chk_to;
        logic       to;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    u8_lock_rst_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RST_HOLD_CYCLES    (4),
`ifdef U8_LOCK_TIMEOUT_EN
        .TIMEOUT_CYCLES     (32),
`endif
        .LOSS_CNT_W         (2)
    ) dut (
        .CLK0         (clk),
        .RESET        (rst),
        .LOCK         (lock),
        .SYS_RST      (sys_rst),
        .READY        (ready),
        .LOSS_CNT     (loss_cnt)
`ifdef U8_LOCK_TIMEOUT_EN
        ,
        .LOCK_TIMEOUT (lock_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string tag(input int id);
        case (id)
            0:       return "reset";
            1:       return "t1_first_lock";
            2:       return "t2_run_loss";
            3:       return "t3_stable_glitch";
            4:       return "t4_loss_sat";
            5:       return "t5_reset_hold_run";
            default: return "t6_timeout";
        endcase
    endfunction

    function automatic logic [1:0] sat3(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    task automatic push(input int c, input logic r, input logic rd, input logic [1:0] l, input int id);
        sb.push_back('{cyc: c, rst: r, rdy: rd, loss: l, chk_to: 1'b0, to: 1'b0, id: id});
    endtask

    task automatic push_to(input int c, input logic r, input logic rd, input logic [1:0] l,
                           input logic t, input int id);
        sb.push_back('{cyc: c, rst: r, rdy: rd, loss: l, chk_to: 1'b1, to: t, id: id});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: pops every expectation due by this edge and compares.
    initial begin
        exp_t e;
        logic bad;
        logic to_act;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e      = sb.pop_front();
                to_act = 1'b0;
`ifdef U8_LOCK_TIMEOUT_EN
                to_act = lock_timeout;
`endif
                bad = (e.cyc != cyc) || (sys_rst !== e.rst) || (ready !== e.rdy) ||
                      (loss_cnt !== e.loss) || (e.chk_to && (to_act !== e.to));
                n_tests++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d(due %0d): sys_rst=%b ready=%b loss=%0d to=%b, expected sys_rst=%b ready=%b loss=%0d to=%b",
                             tag(e.id), cyc, e.cyc, sys_rst, ready, loss_cnt, to_act,
                             e.rst, e.rdy, e.loss, e.to);
                end
            end
        end
    end

    initial begin
        int c;
        int c4;
        rst  = 1'b1;
        lock = 1'b0;

        // Reset, then LOCK held high from the first post-reset edge
        repeat (2) @(negedge clk);
        push(cyc + 1, 1'b1, 1'b0, 2'd0, 0);
        @(negedge clk);
        rst  = 1'b0;
        lock = 1'b1;
        c    = cyc;
        push(c + 14, 1'b1, 1'b0, 2'd0, 1);
        push(c + 15, 1'b0, 1'b1, 2'd0, 1);
        wait_cyc(c + 16);

        // Single-cycle lock loss in RUN
        c    = cyc;
        lock = 1'b0;
        push(c + 2,  1'b0, 1'b1, 2'd0, 2);
        push(c + 3,  1'b1, 1'b0, 2'd1, 2);
        push(c + 15, 1'b1, 1'b0, 2'd1, 2);
        push(c + 16, 1'b0, 1'b1, 2'd1, 2);
        @(negedge clk);
        lock = 1'b1;
        wait_cyc(c + 17);

        // Leave RUN, then glitch LOCK while stab_cnt is 5
        c    = cyc;
        lock = 1'b0;
        push(c + 2, 1'b0, 1'b1, 2'd1, 3);
        push(c + 3, 1'b1, 1'b0, 2'd2, 3);
        wait_cyc(c + 4);
        c4   = cyc;
        lock = 1'b1;
        for (int k = 1; k <= 20; k++) push(c4 + k, 1'b1, 1'b0, 2'd2, 3);
        push(c4 + 21, 1'b0, 1'b1, 2'd2, 3);
        wait_cyc(c4 + 5);
        lock = 1'b0;
        wait_cyc(c4 + 6);
        lock = 1'b1;
        wait_cyc(c4 + 22);

        // RESET in RUN, then RESET in HOLD
        c   = cyc;
        rst = 1'b1;
        push(c + 1, 1'b1, 1'b0, 2'd0, 5);
        push(c + 12, 1'b1, 1'b0, 2'd0, 5);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(c + 12);
        rst = 1'b1;
        push(c + 13, 1'b1, 1'b0, 2'd0, 5);
        @(negedge clk);
        rst = 1'b0;
        c   = cyc;
        push(c + 14, 1'b1, 1'b0, 2'd0, 5);
        push(c + 15, 1'b0, 1'b1, 2'd0, 5);
        wait_cyc(c + 16);

        // Five lock losses from RUN; counter saturates at 3
        for (int n = 1; n <= 5; n++) begin
            c    = cyc;
            lock = 1'b0;
            push(c + 3,  1'b1, 1'b0, sat3(n), 4);
            push(c + 16, 1'b0, 1'b1, sat3(n), 4);
            @(negedge clk);
            lock = 1'b1;
            wait_cyc(c + 17);
        end

        n_tests++;
        if (sys_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_loss_sat: sys_rst=%b in RUN after saturation, expected 0", sys_rst);
        end
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_loss_sat: ready=%b in RUN after saturation, expected 1", ready);
        end
        n_tests++;
        if (loss_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL t4_loss_sat: loss_cnt=%0d after 5 losses, expected 3", loss_cnt);
        end

`ifdef U8_LOCK_TIMEOUT_EN
        // Watchdog with LOCK held low after reset
        c   = cyc;
        rst = 1'b1;
        push_to(c + 1, 1'b1, 1'b0, 2'd0, 1'b0, 6);
        @(negedge clk);
        rst  = 1'b0;
        lock = 1'b0;
        c    = cyc;
        push_to(c + 31, 1'b1, 1'b0, 2'd0, 1'b0, 6);
        push_to(c + 32, 1'b1, 1'b0, 2'd0, 1'b1, 6);
        push_to(c + 47, 1'b1, 1'b0, 2'd0, 1'b1, 6);
        push_to(c + 48, 1'b0, 1'b1, 2'd0, 1'b1, 6);
        wait_cyc(c + 33);
        lock = 1'b1;
        wait_cyc(c + 50);
        rst = 1'b1;
        push_to(cyc + 1, 1'b1, 1'b0, 2'd0, 1'b0, 6);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cyc %0d never checked, now cyc %0d",
                     tag(e.id), e.cyc, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
